// File: rtl/xlr8_tone_pkg.sv
// -----------------------------------------------------------------------------
// xlr8_tone_pkg
// Shared definitions for the tone period capture block: prescaler encoding and
// divide values, CTRL/STAT bit positions and the measurement state enum.
// -----------------------------------------------------------------------------
package xlr8_tone_pkg;

   // Prescaler select as written into CTRL[2:1].
   typedef enum logic [1:0] {
      PRE_DIV1   = 2'b00,
      PRE_DIV8   = 2'b01,
      PRE_DIV64  = 2'b10,
      PRE_DIV256 = 2'b11
   } pre_e;

   localparam int unsigned DIV_1   = 1;
   localparam int unsigned DIV_8   = 8;
   localparam int unsigned DIV_64  = 64;
   localparam int unsigned DIV_256 = 256;

   // CTRL bit positions.
   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_PRE_LSB = 1;
   localparam int CTRL_PRE_MSB = 2;
   localparam int CTRL_IE_BIT  = 3;

   // STAT bit positions.
   localparam int STAT_VALID_BIT = 0;
   localparam int STAT_OVR_BIT   = 1;
   localparam int STAT_TOUT_BIT  = 2;
   localparam int STAT_LEVEL_BIT = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_MEASURE = 2'd2
   } state_e;

   // Terminal count of the prescaler: a tick is issued when the prescaler
   // equals divide-1, so /1 ticks on every clock.
   function automatic logic [7:0] pre_limit(input pre_e pre);
      case (pre)
         PRE_DIV1:  return 8'(DIV_1 - 1);
         PRE_DIV8:  return 8'(DIV_8 - 1);
         PRE_DIV64: return 8'(DIV_64 - 1);
         default:   return 8'(DIV_256 - 1);
      endcase
   endfunction

endpackage

// File: rtl/tone_period_core.sv
// -----------------------------------------------------------------------------
// tone_period_core
// Synchronizes tone_in, detects rising edges, runs the prescaler and the
// saturating 16-bit period counter, and sequences IDLE/ARM/MEASURE.
// Ports:
//   clk, rstn     clock, async active-low reset
//   en            CTRL.EN
//   restart       one-clk pulse: EN 0->1 or PRE changed while enabled
//   pre           CTRL.PRE
//   tone_in       asynchronous square wave
//   capture       one-clk pulse: a period has been measured
//   capture_val   period value to load when capture is high
//   tout_set      one-clk pulse: counter has just reached 0xFFFF
//   tone_level    synchronized tone level
// -----------------------------------------------------------------------------
module tone_period_core
   import xlr8_tone_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        en,
   input  logic        restart,
   input  logic [1:0]  pre,
   input  logic        tone_in,
   output logic        capture,
   output logic [15:0] capture_val,
   output logic        tout_set,
   output logic        tone_level
);

   logic [1:0]  sync_q, sync_d;
   logic        prev_q, prev_d;
   state_e      state_q, state_d;
   logic [7:0]  presc_q, presc_d;
   logic [15:0] cnt_q, cnt_d;

   logic        rise;
   logic        tick;
   logic [15:0] cnt_inc;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      sync_d   = {sync_q[0], tone_in};
      prev_d   = sync_q[1];
      rise     = sync_q[1] & ~prev_q;
      tick     = (state_q == ST_MEASURE) && (presc_q == pre_limit(pre_e'(pre)));
      cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

      // The tick landing on the capture clock still belongs to this period.
      capture_val = tick ? cnt_inc : cnt_q;

      state_d  = state_q;
      presc_d  = presc_q;
      cnt_d    = cnt_q;
      capture  = 1'b0;
      tout_set = 1'b0;

      if (restart) begin
         state_d = ST_ARM;
         presc_d = '0;
         cnt_d   = '0;
      end else if (!en) begin
         state_d = ST_IDLE;
         presc_d = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_ARM;
            ST_ARM: begin
               if (rise) begin
                  state_d = ST_MEASURE;
                  presc_d = '0;
                  cnt_d   = '0;
               end
            end
            ST_MEASURE: begin
               if (rise) begin
                  capture = 1'b1;
                  presc_d = '0;
                  cnt_d   = '0;
               end else if (tick) begin
                  presc_d  = '0;
                  cnt_d    = cnt_inc;
                  tout_set = (cnt_q == 16'hFFFE);
               end else begin
                  presc_d = presc_q + 8'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign tone_level = sync_q[1];

   // NOTE: state is updated only with non-blocking assignments so every flop
   // samples values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         state_q <= ST_IDLE;
         presc_q <= '0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         state_q <= state_d;
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/xlr8_tone_capture.sv
// -----------------------------------------------------------------------------
// xlr8_tone_capture
// AVR data-memory mapped tone period capture: bus decode, CTRL/PERIOD/STAT
// registers, atomic 16-bit read shadow and the level interrupt.
// Ports:
//   clk, rstn            clock, async active-low reset
//   clken                AVR clock enable (qualifies writes and read effects)
//   dbus_in / dbus_out   AVR write / read data
//   io_out_en            high while the AVR reads one of our addresses
//   ramadr, ramre, ramwe, dm_sel   data-memory bus
//   tone_in              asynchronous square wave
//   tone_irq             registered IE & VALID
// -----------------------------------------------------------------------------
module xlr8_tone_capture
   import xlr8_tone_pkg::*;
#(
   parameter int TONE_CTRL_ADDR = 0,
   parameter int TONE_PERL_ADDR = 0,
   parameter int TONE_PERH_ADDR = 0,
   parameter int TONE_STAT_ADDR = 0
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       clken,
   input  logic [7:0] dbus_in,
   output logic [7:0] dbus_out,
   output logic       io_out_en,
   input  logic [7:0] ramadr,
   input  logic       ramre,
   input  logic       ramwe,
   input  logic       dm_sel,
   input  logic       tone_in,
   output logic       tone_irq
);

   localparam logic [7:0] CTRL_A = 8'(TONE_CTRL_ADDR);
   localparam logic [7:0] PERL_A = 8'(TONE_PERL_ADDR);
   localparam logic [7:0] PERH_A = 8'(TONE_PERH_ADDR);
   localparam logic [7:0] STAT_A = 8'(TONE_STAT_ADDR);

   logic [3:0]  ctrl_q, ctrl_d;
   logic [15:0] period_q, period_d;
   logic [7:0]  shadow_q, shadow_d;
   logic [2:0]  stat_q, stat_d;
   logic        irq_q, irq_d;

   logic sel_ctrl, sel_perl, sel_perh, sel_stat;
   logic ctrl_we, stat_we, perl_rd, restart;
   logic [2:0] stat_set, stat_clr;

   logic        capture, tout_set, tone_level;
   logic [15:0] capture_val;

   // Upper write-data bits have no storage behind them.
   logic unused_dbus;
   assign unused_dbus = ^dbus_in[7:4];

   tone_period_core u_core (
      .clk         (clk),
      .rstn        (rstn),
      .en          (ctrl_q[CTRL_EN_BIT]),
      .restart     (restart),
      .pre         (ctrl_q[CTRL_PRE_MSB:CTRL_PRE_LSB]),
      .tone_in     (tone_in),
      .capture     (capture),
      .capture_val (capture_val),
      .tout_set    (tout_set),
      .tone_level  (tone_level)
   );

   always_comb begin
      sel_ctrl  = dm_sel && (ramadr == CTRL_A);
      sel_perl  = dm_sel && (ramadr == PERL_A);
      sel_perh  = dm_sel && (ramadr == PERH_A);
      sel_stat  = dm_sel && (ramadr == STAT_A);
      io_out_en = (sel_ctrl | sel_perl | sel_perh | sel_stat) & ramre;

      ctrl_we = sel_ctrl & ramwe & clken;
      stat_we = sel_stat & ramwe & clken;
      perl_rd = sel_perl & ramre & clken;

      // Re-arm when the block is being switched on, or when the prescaler
      // changes under a running measurement.
      restart = ctrl_we & dbus_in[CTRL_EN_BIT] &
                (~ctrl_q[CTRL_EN_BIT] |
                 (dbus_in[CTRL_PRE_MSB:CTRL_PRE_LSB] != ctrl_q[CTRL_PRE_MSB:CTRL_PRE_LSB]));

      ctrl_d   = ctrl_we ? dbus_in[3:0] : ctrl_q;
      period_d = capture ? capture_val : period_q;
      shadow_d = perl_rd ? period_q[15:8] : shadow_q;

      // Set has priority over a write-1-to-clear in the same cycle.
      stat_set = '0;
      stat_set[STAT_VALID_BIT] = capture;
      stat_set[STAT_OVR_BIT]   = capture & stat_q[STAT_VALID_BIT];
      stat_set[STAT_TOUT_BIT]  = tout_set;
      stat_clr = stat_we ? dbus_in[2:0] : 3'b000;
      stat_d   = stat_set | (stat_q & ~stat_clr);

      irq_d = ctrl_q[CTRL_IE_BIT] & stat_q[STAT_VALID_BIT];

      if (sel_ctrl)      dbus_out = {4'b0000, ctrl_q};
      else if (sel_perl) dbus_out = period_q[7:0];
      else if (sel_perh) dbus_out = shadow_q;
      else if (sel_stat) dbus_out = {4'b0000, tone_level, stat_q};
      else               dbus_out = 8'h00;
   end

   assign tone_irq = irq_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ctrl_q   <= '0;
         period_q <= '0;
         shadow_q <= '0;
         stat_q   <= '0;
         irq_q    <= 1'b0;
      end else begin
         ctrl_q   <= ctrl_d;
         period_q <= period_d;
         shadow_q <= shadow_d;
         stat_q   <= stat_d;
         irq_q    <= irq_d;
      end
   end

endmodule

// File: doc/xlr8_tone_capture.md
XLR8_TONE_CAPTURE -- requirements
Module: xlr8_tone_capture

Interface
REQ-001 The block SHALL have parameter TONE_CTRL_ADDR, default 0, meaning the data-memory address of the R/W control register.
REQ-002 The block SHALL have parameter TONE_PERL_ADDR, default 0, meaning the address of the read-only period low byte.
REQ-003 The block SHALL have parameter TONE_PERH_ADDR, default 0, meaning the address of the read-only period high byte.
REQ-004 The block SHALL have parameter TONE_STAT_ADDR, default 0, meaning the address of the status register, with write-1-to-clear bits.
REQ-005 The block SHALL have the following ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- clken  in  1  AVR clock enable; qualifies register writes and read side effects.
- dbus_in  in  8  AVR write data.
- dbus_out  out  8  AVR read data.
- io_out_en  out  1  high while the AVR reads any of the block's addresses.
- ramadr  in  8  data-memory address.
- ramre  in  1  read strobe.
- ramwe  in  1  write strobe.
- dm_sel  in  1  data-memory select.
- tone_in  in  1  asynchronous external square wave.
- tone_irq  out  1  level interrupt request.

Function
REQ-006 A register SHALL be selected when dm_sel=1 and ramadr equals its address; io_out_en SHALL equal (any select) & ramre.
REQ-007 When nothing is selected, dbus_out SHALL be 0x00.
REQ-008 CTRL register fields SHALL be:
- bit0 EN.
- bits2:1 PRE: 00 /1, 01 /8, 10 /64, 11 /256.
- bit3 IE.
- bits7:4 read as 0.
REQ-009 CTRL writes SHALL occur only when clken=1 and the CTRL write select is active.
REQ-010 tone_in SHALL pass through a 2-flop synchronizer; a rising edge SHALL be detected one cycle after the second flop, giving 3 clk total from the pin.
REQ-011 When EN=1, the prescaler SHALL produce a one-clk tick every 1, 8, 64 or 256 clk, as selected by PRE.
REQ-012 The 16-bit period counter SHALL increment on each tick and saturate at 0xFFFF.
REQ-013 Reaching 0xFFFF SHALL set STAT.TOUT (bit2).
REQ-014 Measurement states SHALL be IDLE, ARM and MEASURE:
- IDLE is entered when EN=0.
- ARM is entered on EN 0->1 and waits for the first rising edge.
- On that edge, ARM SHALL go to MEASURE with the counter cleared.
REQ-015 On each rising edge in MEASURE, the block SHALL, in the same cycle:
- load the counter value into PERIOD;
- clear the counter and prescaler, so the tick phase restarts;
- set STAT.VALID (bit0).
REQ-016 If VALID is already 1 at a capture, STAT.OVR (bit1) SHALL be set and PERIOD SHALL still be overwritten.
REQ-017 A PERL read with clken=1 SHALL return PERIOD[7:0] and copy PERIOD[15:8] into a shadow register. A PERH read SHALL return the shadow, so a 16-bit read is atomic.
REQ-018 Writing 1 to a STAT bit SHALL clear it; writing 0 SHALL have no effect. If a set and a clear hit the same bit in the same cycle, the set SHALL win.
REQ-019 STAT bit3 SHALL read the current synchronized tone level. STAT bits7:4 SHALL read as 0.
REQ-020 tone_irq SHALL be registered and equal IE & VALID, one clk after either changes.
REQ-021 Clearing EN SHALL:
- clear the counter, prescaler and state (back to IDLE);
- retain PERIOD and STAT.
REQ-022 Edges while in IDLE SHALL be ignored.
REQ-023 Changing PRE while EN=1 SHALL restart the prescaler and return the state to ARM.

Reset
REQ-024 While rstn=0, the following SHALL be 0:
- CTRL, PERIOD, shadow, STAT, counter, prescaler and synchronizer flops;
- state (IDLE);
- tone_irq and dbus_out.
REQ-025 Reset mid-measurement SHALL discard the capture in progress; no VALID is set after reset release until EN is written again.

Structure
REQ-026 Package xlr8_tone_pkg SHALL hold:
- the PRE encoding enum and divide values;
- CTRL and STAT bit-position constants;
- the state enum.
REQ-027 Sub-module tone_period_core SHALL contain the synchronizer, edge detect, prescaler, counter, state machine and capture. The top level SHALL hold the bus decode, registers, shadow and IRQ.

Verification
REQ-028 EN=1, PRE=00, tone_in period 100 clk -> after the second rising edge PERIOD=100 (0x0064), VALID=1, OVR=0.
REQ-029 PRE=01, tone_in period 800 clk -> PERIOD=100. Three edges without a STAT clear -> OVR=1.
REQ-030 Read PERL while PERIOD=0x12FF, a capture changes PERIOD to 0x1300, then read PERH -> bytes read are 0xFF and 0x12.
REQ-031 IE=1, capture occurs -> tone_irq=1 one clk after VALID. Write STAT=0x01 in the same cycle as a new capture -> VALID stays 1.
REQ-032 PRE=00, tone_in held low after arming -> counter stops at 0xFFFF, TOUT=1. Then an edge -> PERIOD=0xFFFF.
REQ-033 rstn pulsed low mid-measure -> all registers 0x00. An edge after release with EN=0 -> VALID stays 0.
